memory_access: RTL and testbench

- Pipeline stage directly downstream of the execute stage. Consumes the EX/MEM register contents: write-back control, memory-access control, ALU result, store data and destination register.
- Performs data-memory loads and stores against an internal word-addressed RAM with a configurable multi-cycle access latency. Asserts a stall to upstream stages while an access is in flight.
- Selects the write-back value and drives the MEM/WB register. Those outputs feed the register file and the execute stage's MEM/WB forwarding inputs.

---
 rtl/memory_access.sv | 91 +++++++++
 tb/tb_memory_access.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// MEM pipeline stage: multi-cycle data-memory access against a word-addressed RAM,
// upstream stall while an access is in flight, and MEM/WB register drive.
module memory_access #(
  parameter int DEPTH       = 256,
  parameter int ADDR_BITS   = 8,
  parameter int MEM_LATENCY = 3
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [1:0]  writeBackControlIn,
  input  logic [1:0]  memAccessControlIn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic [4:0]  rdIn,
  output logic        stall,
  output logic        memWbRegWrite,
  output logic [4:0]  memWbRd,
  output logic [31:0] memWbData
);

  localparam int CNT_BITS = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(MEM_LATENCY - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state, stateNext;
  logic [CNT_BITS-1:0] cnt, cntNext;

  logic                 regWrite, memToReg, memRead, memWrite, memOp;
  logic [ADDR_BITS-1:0] index;
  logic [31:0]          ramWord;
  logic                 unusedAddrBits;

  // Zero at time zero only; reset never clears the array.
  logic [31:0] mem [DEPTH] = '{default: '0};

  assign regWrite = writeBackControlIn[1];
  assign memToReg = writeBackControlIn[0];
  assign memRead  = memAccessControlIn[1];
  assign memWrite = memAccessControlIn[0];
  assign memOp    = memRead | memWrite;

  assign index          = address[ADDR_BITS+1:2];
  assign unusedAddrBits = ^{address[31:ADDR_BITS+2], address[1:0]};
  assign ramWord        = mem[index];

  // IDLE implies cnt==0, so the IDLE branch only stalls when latency exceeds one.
  always_comb begin
    stall     = 1'b0;
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE:    stall = memOp && (LAST != '0);
      WAIT:    stall = memOp && (cnt != LAST);
      default: stall = 1'b0;
    endcase
    if (stall) begin
      cntNext   = cnt + 1'b1;
      stateNext = WAIT;
    end else begin
      cntNext   = '0;
      stateNext = IDLE;
    end
  end

  always_ff @(negedge clk) begin
    if (!resetN) begin
      state         <= IDLE;
      cnt           <= '0;
      memWbRegWrite <= 1'b0;
      memWbRd       <= '0;
      memWbData     <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (stall) begin
        memWbRegWrite <= 1'b0;
      end else begin
        memWbRegWrite <= regWrite;
        memWbRd       <= rdIn;
        memWbData     <= memToReg ? ramWord : address;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (resetN && !stall && memWrite)
      mem[index] <= writeData;
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: a MEM_LATENCY=3 instance for the main
// sequences and a MEM_LATENCY=1 instance for back-to-back single-cycle ops.
module tb_memory_access;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        resetN;
  logic [1:0]  wbCtl, memCtl;
  logic [31:0] address, writeData;
  logic [4:0]  rdIn;
  logic        stall, memWbRegWrite;
  logic [4:0]  memWbRd;
  logic [31:0] memWbData;

  logic        resetN1;
  logic [1:0]  wbCtl1, memCtl1;
  logic [31:0] address1, writeData1;
  logic [4:0]  rdIn1;
  logic        stall1, memWbRegWrite1;
  logic [4:0]  memWbRd1;
  logic [31:0] memWbData1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  memory_access #(.DEPTH(256), .ADDR_BITS(8), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .resetN(resetN),
    .writeBackControlIn(wbCtl), .memAccessControlIn(memCtl),
    .address(address), .writeData(writeData), .rdIn(rdIn),
    .stall(stall), .memWbRegWrite(memWbRegWrite),
    .memWbRd(memWbRd), .memWbData(memWbData)
  );

  memory_access #(.DEPTH(256), .ADDR_BITS(8), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .resetN(resetN1),
    .writeBackControlIn(wbCtl1), .memAccessControlIn(memCtl1),
    .address(address1), .writeData(writeData1), .rdIn(rdIn1),
    .stall(stall1), .memWbRegWrite(memWbRegWrite1),
    .memWbRd(memWbRd1), .memWbData(memWbData1)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic edgeStep();
    @(negedge clk);
    #1;
  endtask

  // Apply one op and walk it through the stage, checking stall and bubbles each cycle.
  task automatic doOp(input logic [1:0] wb, input logic [1:0] mc,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    wbCtl = wb; memCtl = mc; address = addr; writeData = wd; rdIn = rd;
    #1;
    if (mc != 2'b00) begin
      for (int unsigned i = 0; i < LAT - 1; i++) begin
        checkVal("stallHigh", stall, 1);
        edgeStep();
        checkVal("bubble", memWbRegWrite, 0);
      end
    end
    checkVal("stallLow", stall, 0);
    edgeStep();
  endtask

  initial begin
    resetN = 1'b0; wbCtl = '0; memCtl = '0; address = '0; writeData = '0; rdIn = '0;
    resetN1 = 1'b0; wbCtl1 = '0; memCtl1 = '0; address1 = '0; writeData1 = '0; rdIn1 = '0;
    edgeStep();
    edgeStep();
    checkVal("rstRegWrite", memWbRegWrite, 0);
    checkVal("rstRd", memWbRd, 0);
    checkVal("rstData", memWbData, 0);
    checkVal("rstStall", stall, 0);

    // ALU pass-through
    resetN = 1'b1;
    doOp(2'b10, 2'b00, 32'h1234, 32'h0, 5'd5);
    checkVal("passRegWrite", memWbRegWrite, 1);
    checkVal("passRd", memWbRd, 5);
    checkVal("passData", memWbData, 32'h1234);

    // Store: first stall edge holds rd/data from previous op
    wbCtl = 2'b00; memCtl = 2'b01; address = 32'h10; writeData = 32'hDEADBEEF; rdIn = 5'd3;
    #1;
    checkVal("stStall0", stall, 1);
    edgeStep();
    checkVal("stHoldRd", memWbRd, 5);
    checkVal("stHoldData", memWbData, 32'h1234);
    checkVal("stBubble", memWbRegWrite, 0);
    checkVal("stStall1", stall, 1);
    edgeStep();
    checkVal("stStall2", stall, 0);
    edgeStep();
    checkVal("stDoneRegWrite", memWbRegWrite, 0);
    checkVal("stDoneRd", memWbRd, 3);
    checkVal("stDoneData", memWbData, 32'h10);

    doOp(2'b11, 2'b10, 32'h10, 32'h0, 5'd9);
    checkVal("ldData", memWbData, 32'hDEADBEEF);
    checkVal("ldRd", memWbRd, 9);
    checkVal("ldRegWrite", memWbRegWrite, 1);

    // Address wrap: 0x400 maps to word 0
    doOp(2'b00, 2'b01, 32'h400, 32'hA5A5A5A5, 5'd1);
    doOp(2'b11, 2'b10, 32'h0, 32'h0, 5'd2);
    checkVal("wrapData", memWbData, 32'hA5A5A5A5);
    doOp(2'b11, 2'b10, 32'h13, 32'h0, 5'd2);
    checkVal("lowBitsIgnored", memWbData, 32'hDEADBEEF);

    // Reset mid-access aborts the pending store
    wbCtl = 2'b00; memCtl = 2'b01; address = 32'h20; writeData = 32'h55; rdIn = 5'd7;
    edgeStep();
    resetN = 1'b0;
    edgeStep();
    checkVal("abortRegWrite", memWbRegWrite, 0);
    checkVal("abortRd", memWbRd, 0);
    checkVal("abortData", memWbData, 0);
    resetN = 1'b1; memCtl = 2'b00;
    #1;
    checkVal("abortStall", stall, 0);
    doOp(2'b11, 2'b10, 32'h20, 32'h0, 5'd8);
    checkVal("abortLoad", memWbData, 32'h0);

    // Read-before-write on combined memRead|memWrite
    doOp(2'b00, 2'b01, 32'h8, 32'd7, 5'd0);
    doOp(2'b11, 2'b11, 32'h8, 32'd9, 5'd4);
    checkVal("rbwData", memWbData, 32'd7);
    checkVal("rbwRd", memWbRd, 4);
    doOp(2'b11, 2'b10, 32'h8, 32'h0, 5'd6);
    checkVal("rbwLater", memWbData, 32'd9);

    // memToReg without a memory op: single-cycle read, no stall
    doOp(2'b11, 2'b00, 32'h10, 32'h0, 5'd10);
    checkVal("combRead", memWbData, 32'hDEADBEEF);

    // Store with regWrite=1 still writes back the address value
    doOp(2'b10, 2'b01, 32'h30, 32'h77, 5'd11);
    checkVal("stRegWrite", memWbRegWrite, 1);
    checkVal("stRegData", memWbData, 32'h30);

    // MEM_LATENCY=1: ten back-to-back mixed ops, never stalling
    resetN1 = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        wbCtl1 = 2'b00; memCtl1 = 2'b01; address1 = 32'(i * 4);
        writeData1 = 32'hC0DE0000 | 32'(i); rdIn1 = 5'(i);
      end else begin
        wbCtl1 = 2'b11; memCtl1 = 2'b10; address1 = 32'((i - 1) * 4);
        writeData1 = '0; rdIn1 = 5'(i);
      end
      #1;
      checkVal("lat1Stall", stall1, 0);
      edgeStep();
      if (i % 2 == 0) begin
        checkVal("lat1StData", memWbData1, 32'(i * 4));
        checkVal("lat1StRegWrite", memWbRegWrite1, 0);
      end else begin
        checkVal("lat1LdData", memWbData1, 32'hC0DE0000 | 32'(i - 1));
        checkVal("lat1LdRegWrite", memWbRegWrite1, 1);
      end
      checkVal("lat1Rd", memWbRd1, 32'(i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
